keypad_event_ctrl: RTL and testbench

Controller that sits behind the 4x4 keypad scanner and turns its raw 16-bit key vector into a queue of press events. The raw vector is active-low. The block synchronizes the vector, samples it at a programmable rate, and debounces each key independently. Each debounced press is serialized by key index into a small FIFO, which a consumer (display/calculator logic) drains over a valid/ready handshake.

---
 rtl/keypad_event_ctrl.sv | 168 ++++++++++++++++
 tb/tb_keypad_event_ctrl.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_event_ctrl.sv
// keypad_event_ctrl: synchronizes and debounces an active-low 16-key vector,
// then queues key-press events (by key index) into a small FIFO that a
// consumer drains over a valid/ready handshake.
module keypad_event_ctrl #(
  parameter int SAMPLE_DIV = 50000,
  parameter int DEBOUNCE   = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [15:0]                   key_raw,
  output logic [15:0]                   key_state,
  output logic [3:0]                    key_code,
  output logic                          key_valid,
  input  logic                          key_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow
);

  localparam int CW = $clog2(SAMPLE_DIV);
  localparam int SW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] CNT_MAX  = CW'(SAMPLE_DIV - 1);
  localparam logic [SW-1:0] STAB_MAX = SW'(DEBOUNCE - 1);
  localparam logic [PW:0]   DEPTH    = (PW + 1)'(FIFO_DEPTH);

  // Synchronizer and sampler state
  logic [15:0]   sync1_q, sync1_d;
  logic [15:0]   sync2_q, sync2_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [15:0]   prev_q, prev_d;
  logic [SW-1:0] stab_q [16];
  logic [SW-1:0] stab_d [16];
  logic [15:0]   key_state_q, key_state_d;

  // Event queue state
  logic [15:0]   pend_q, pend_d;
  logic          overflow_q, overflow_d;
  logic [3:0]    mem_q [FIFO_DEPTH];
  logic [3:0]    mem_d [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW:0]   count_q, count_d;
  logic          key_valid_q, key_valid_d;
  logic [3:0]    key_code_q, key_code_d;

  logic          sample_tick;
  logic [15:0]   press;
  logic          pop;
  logic          push;
  logic [3:0]    push_idx;
  logic [15:0]   push_mask;

  assign sample_tick = (cnt_q == CNT_MAX);

  // Synchronizer, sample counter and per-key debounce
  always_comb begin
    logic [SW-1:0] stab_new;
    sync1_d     = key_raw;
    sync2_d     = sync1_q;
    cnt_d       = sample_tick ? '0 : cnt_q + 1'b1;
    prev_d      = prev_q;
    key_state_d = key_state_q;
    stab_new    = '0;
    for (int i = 0; i < 16; i++) begin
      stab_d[i] = stab_q[i];
      if (sample_tick) begin
        if (sync2_q[i] == prev_q[i]) begin
          stab_new = (stab_q[i] == STAB_MAX) ? STAB_MAX : SW'(stab_q[i] + 1'b1);
        end else begin
          stab_new = '0;
        end
        stab_d[i] = stab_new;
        prev_d[i] = sync2_q[i];
        // A level is accepted once DEBOUNCE identical samples are seen in a row
        if ((stab_new == STAB_MAX) && (~sync2_q[i] != key_state_q[i])) begin
          key_state_d[i] = ~sync2_q[i];
        end
      end
    end
    press = key_state_d & ~key_state_q;
  end

  // Pending-event serializer and FIFO bookkeeping
  always_comb begin
    pop      = key_valid_q & key_ready;
    push_idx = '0;
    // Scan downward so the lowest set index wins
    for (int i = 15; i >= 0; i--) begin
      if (pend_q[i]) begin
        push_idx = 4'(i);
      end
    end
    push      = (pend_q != '0) && ((count_q < DEPTH) || pop);
    push_mask = push ? (16'b1 << push_idx) : '0;

    pend_d = (pend_q & ~push_mask) | press;
    // A press is lost only if its pending slot is still occupied after this cycle's push
    overflow_d = overflow_q | (|(press & pend_q & ~push_mask));

    mem_d = mem_q;
    if (push) begin
      mem_d[wr_ptr_q] = push_idx;
    end
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;

    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    // Head of queue is registered so it is stable while the consumer stalls
    key_valid_d = (count_d != '0);
    key_code_d  = mem_d[rd_ptr_d];
  end

  // State register with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q     <= '1;
      sync2_q     <= '1;
      cnt_q       <= '0;
      prev_q      <= '1;
      key_state_q <= '0;
      pend_q      <= '0;
      overflow_q  <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      key_valid_q <= 1'b0;
      key_code_q  <= '0;
      for (int i = 0; i < 16; i++) begin
        stab_q[i] <= '0;
      end
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      cnt_q       <= cnt_d;
      prev_q      <= prev_d;
      key_state_q <= key_state_d;
      pend_q      <= pend_d;
      overflow_q  <= overflow_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      key_valid_q <= key_valid_d;
      key_code_q  <= key_code_d;
      for (int i = 0; i < 16; i++) begin
        stab_q[i] <= stab_d[i];
      end
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  assign key_state  = key_state_q;
  assign key_code   = key_code_q;
  assign key_valid  = key_valid_q;
  assign fifo_count = count_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_keypad_event_ctrl.sv
// Bench for keypad_event_ctrl: directed scenarios followed by a random phase,
// every cycle compared against a run-length / queue reference model.
module tb_keypad_event_ctrl;

  localparam int SD = 4;
  localparam int DB = 3;
  localparam int FD = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] key_raw = 16'hFFFF;
  logic        key_ready = 1'b0;
  logic [15:0] key_state;
  logic [3:0]  key_code;
  logic        key_valid;
  logic [2:0]  fifo_count;
  logic        overflow;

  int checks = 0;
  int failures = 0;

  // Reference model state
  logic [15:0] m_sync1, m_sync2;
  int          m_cnt;
  logic        m_last [16];
  int          m_run  [16];
  logic [15:0] m_state;
  logic [15:0] m_pend;
  logic        m_ovf;
  int          m_q [$];

  keypad_event_ctrl #(.SAMPLE_DIV(SD), .DEBOUNCE(DB), .FIFO_DEPTH(FD)) dut (
    .clk        (clk),
    .rst        (rst),
    .key_raw    (key_raw),
    .key_state  (key_state),
    .key_code   (key_code),
    .key_valid  (key_valid),
    .key_ready  (key_ready),
    .fifo_count (fifo_count),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_sync1 = '1;
    m_sync2 = '1;
    m_cnt   = 0;
    for (int i = 0; i < 16; i++) begin
      m_last[i] = 1'b1;
      m_run[i]  = 1;
    end
    m_state = '0;
    m_pend  = '0;
    m_ovf   = 1'b0;
    m_q.delete();
  endtask

  // Predict the effect of the coming clock edge from current inputs.
  task automatic model_edge();
    bit mpop, mpush;
    int pidx;
    logic s;
    if (rst) begin
      model_reset();
      return;
    end
    mpop  = (m_q.size() > 0) && key_ready;
    mpush = (m_pend != 0) && ((m_q.size() < FD) || mpop);
    pidx  = -1;
    for (int i = 0; i < 16; i++) begin
      if (m_pend[i] && pidx < 0) pidx = i;
    end
    if (mpop) void'(m_q.pop_front());
    if (mpush) begin
      m_q.push_back(pidx);
      m_pend[pidx] = 1'b0;
    end
    if (m_cnt == SD - 1) begin
      for (int i = 0; i < 16; i++) begin
        s = m_sync2[i];
        if (s == m_last[i]) m_run[i]++;
        else m_run[i] = 1;
        m_last[i] = s;
        // Held level (active-high) is ~s; accept it once the run is long enough
        if (m_run[i] >= DB && m_state[i] == s) begin
          m_state[i] = ~s;
          if (!s) begin
            if (m_pend[i]) m_ovf = 1'b1;
            m_pend[i] = 1'b1;
          end
        end
      end
    end
    m_cnt   = (m_cnt + 1) % SD;
    m_sync2 = m_sync1;
    m_sync1 = key_raw;
  endtask

  task automatic step();
    if (!rst && key_valid && key_ready) $display("pop key_code=%0d", key_code);
    model_edge();
    @(posedge clk);
    #1;
    chk("key_state", 32'(key_state), 32'(m_state));
    chk("key_valid", 32'(key_valid), 32'(m_q.size() != 0));
    chk("fifo_count", 32'(fifo_count), 32'(m_q.size()));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    if (m_q.size() > 0) chk("key_code", 32'(key_code), 32'(m_q[0]));
  endtask

  task automatic wait_bit(input int b, input logic v, input int maxc, input string tag, output int n);
    n = 0;
    while (key_state[b] !== v && n < maxc) begin
      step();
      n++;
    end
    chk(tag, 32'(key_state[b]), 32'(v));
  endtask

  task automatic wait_valid(input int maxc, input string tag);
    int n = 0;
    while (key_valid !== 1'b1 && n < maxc) begin
      step();
      n++;
    end
    chk(tag, 32'(key_valid), 32'd1);
  endtask

  initial begin
    int n;
    int idx;
    model_reset();

    // Reset held for three cycles
    rst = 1'b1;
    key_raw = 16'hFFFF;
    repeat (3) step();
    chk("rst_key_state", 32'(key_state), 32'd0);
    chk("rst_key_valid", 32'(key_valid), 32'd0);
    chk("rst_fifo_count", 32'(fifo_count), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_key_code", 32'(key_code), 32'd0);
    rst = 1'b0;

    // Single press of key 5
    key_raw[5] = 1'b0;
    wait_bit(5, 1'b1, 20, "press5", n);
    chk("press5_latency_le14", 32'(n <= 2 + DB * SD), 32'd1);
    step();
    chk("ev5_valid", 32'(key_valid), 32'd1);
    chk("ev5_code", 32'(key_code), 32'd5);
    chk("ev5_count", 32'(fifo_count), 32'd1);
    key_ready = 1'b1;
    step();
    key_ready = 1'b0;
    chk("ev5_pop_valid", 32'(key_valid), 32'd0);
    chk("ev5_pop_count", 32'(fifo_count), 32'd0);
    key_raw[5] = 1'b1;
    wait_bit(5, 1'b0, 20, "release5", n);
    repeat (4) step();

    // Bounce on key 9: toggles every sample period
    for (int p = 0; p < 6; p++) begin
      key_raw[9] = ~key_raw[9];
      repeat (SD) step();
      chk("bounce9_state", 32'(key_state[9]), 32'd0);
    end
    key_raw[9] = 1'b1;
    repeat (16) step();
    chk("bounce9_final_state", 32'(key_state[9]), 32'd0);
    chk("bounce9_no_event", 32'(key_valid), 32'd0);

    // Simultaneous presses of keys 3 and 12
    key_ready = 1'b1;
    key_raw[3]  = 1'b0;
    key_raw[12] = 1'b0;
    wait_valid(25, "sim_first_valid");
    chk("sim_code3", 32'(key_code), 32'd3);
    step();
    chk("sim_valid12", 32'(key_valid), 32'd1);
    chk("sim_code12", 32'(key_code), 32'd12);
    step();
    chk("sim_empty", 32'(key_valid), 32'd0);
    key_raw[3]  = 1'b1;
    key_raw[12] = 1'b1;
    key_ready = 1'b0;
    repeat (20) step();

    // Overflow: fill FIFO, leave key 4 pending, then press key 4 again
    for (int k = 0; k < 5; k++) begin
      key_raw[k] = 1'b0;
      wait_bit(k, 1'b1, 20, "ovf_press", n);
      key_raw[k] = 1'b1;
      wait_bit(k, 1'b0, 20, "ovf_release", n);
    end
    repeat (2) step();
    chk("ovf_count_full", 32'(fifo_count), 32'd4);
    chk("ovf_pend4", 32'(dut.pend_q[4]), 32'd1);
    chk("ovf_not_yet", 32'(overflow), 32'd0);
    key_raw[4] = 1'b0;
    wait_bit(4, 1'b1, 20, "ovf_repress4", n);
    chk("ovf_set", 32'(overflow), 32'd1);
    key_raw[4] = 1'b1;
    wait_bit(4, 1'b0, 20, "ovf_rerelease4", n);
    key_ready = 1'b1;
    for (int j = 0; j < 5; j++) begin
      chk("drain_valid", 32'(key_valid), 32'd1);
      chk("drain_code", 32'(key_code), 32'(j));
      step();
    end
    chk("drain_empty", 32'(key_valid), 32'd0);
    chk("drain_ovf_sticky", 32'(overflow), 32'd1);
    key_ready = 1'b0;

    // Reset in the middle of operation
    key_raw[7] = 1'b0;
    key_raw[8] = 1'b0;
    wait_bit(7, 1'b1, 20, "mid_press7", n);
    wait_bit(8, 1'b1, 20, "mid_press8", n);
    repeat (2) step();
    chk("mid_count2", 32'(fifo_count), 32'd2);
    chk("mid_state7", 32'(key_state[7]), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_state", 32'(key_state), 32'd0);
    chk("mid_rst_valid", 32'(key_valid), 32'd0);
    chk("mid_rst_count", 32'(fifo_count), 32'd0);
    chk("mid_rst_ovf", 32'(overflow), 32'd0);
    chk("mid_rst_code", 32'(key_code), 32'd0);
    key_raw[8] = 1'b1;
    wait_valid(25, "mid_reevent_valid");
    chk("mid_reevent_code7", 32'(key_code), 32'd7);
    key_ready = 1'b1;
    step();
    key_raw[7] = 1'b1;
    key_ready = 1'b0;
    repeat (20) step();

    // Random phase: sparse key flips, random consumer stalls, rare resets
    for (int c = 0; c < 2000; c++) begin
      if ($urandom_range(0, 15) == 0) begin
        idx = $urandom_range(0, 15);
        key_raw[idx] = ~key_raw[idx];
      end
      key_ready = ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 799) == 0);
      step();
    end
    rst = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
